cache_line_ctrl: RTL and testbench

- Miss/replacement controller for a 4-line fully-associative cache set.
- Performs tag lookup and picks a store line from a candidate mask. A line is a candidate when it is invalid and clean, or when it is the LRU line.
- Sequences the dirty-victim writeback and the line fill with memory over a request/ack handshake.
- Reports hit flag and line index so the external data array can be accessed.

---
 rtl/cache_line_ctrl.sv | 150 +++++++++++++++
 tb/tb_cache_line_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_line_ctrl.sv
// Miss/replacement controller for one 4-line fully-associative cache set.
// Looks up the requested tag, picks a replacement line on a miss, runs the
// dirty-victim writeback and the line fill over a req/ack handshake, and
// reports the hit flag and line index for the external data array.
module cache_line_ctrl #(
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  output logic             resp_hit,
  output logic [1:0]       resp_line,
  output logic             mem_req,
  output logic             mem_we,
  output logic [TAG_W-1:0] mem_tag,
  output logic [1:0]       mem_line,
  input  logic             mem_ack
);

  typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, RESP} state_t;

  state_t                  state_reg;
  logic [3:0]              valid_reg;
  logic [3:0]              dirty_reg;
  logic [3:0][TAG_W-1:0]   tag_reg;
  logic [3:0][1:0]         age_reg;
  logic                    write_reg;
  logic [TAG_W-1:0]        tag_lat_reg;
  logic [1:0]              line_reg;

  logic [3:0]              hit_vec;
  logic [3:0]              cand_vec;
  logic [3:0][1:0]         age_next;
  logic                    hit_any;
  logic [1:0]              hit_idx;
  logic [1:0]              victim_idx;

  // Per-line tag match, replacement candidates and recency update.
  // A line ages only if it was more recent than the accessed line, which
  // keeps the ages a permutation of 0..3.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_line
      assign hit_vec[gi]  = valid_reg[gi] && (tag_reg[gi] == tag_lat_reg);
      assign cand_vec[gi] = (~valid_reg[gi] & ~dirty_reg[gi]) | (age_reg[gi] == 2'd3);
      assign age_next[gi] = (2'(gi) == line_reg) ? 2'd0 :
                            (age_reg[gi] < age_reg[line_reg]) ? age_reg[gi] + 2'd1 :
                            age_reg[gi];
    end
  endgenerate

  // Encode the hit line and the lowest-index replacement candidate.
  always_comb begin
    hit_any    = |hit_vec;
    hit_idx    = 2'd0;
    victim_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (hit_vec[i])  hit_idx    = 2'(i);
      if (cand_vec[i]) victim_idx = 2'(i);
    end
  end

  // Controller FSM with all outputs registered; mem_req rises one cycle
  // after entering WB/FILL so a WB->FILL hand-over always has a low cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      valid_reg   <= '0;
      dirty_reg   <= '0;
      tag_reg     <= '0;
      age_reg     <= {2'd3, 2'd2, 2'd1, 2'd0};
      write_reg   <= 1'b0;
      tag_lat_reg <= '0;
      line_reg    <= 2'd0;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_hit    <= 1'b0;
      resp_line   <= 2'd0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_tag     <= '0;
      mem_line    <= 2'd0;
    end else begin
      resp_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            write_reg   <= req_write;
            tag_lat_reg <= req_tag;
            req_ready   <= 1'b0;
            state_reg   <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit_any) begin
            line_reg   <= hit_idx;
            if (write_reg) dirty_reg[hit_idx] <= 1'b1;
            resp_valid <= 1'b1;
            resp_hit   <= 1'b1;
            resp_line  <= hit_idx;
            state_reg  <= RESP;
          end else begin
            line_reg <= victim_idx;
            if (valid_reg[victim_idx] && dirty_reg[victim_idx]) state_reg <= WB;
            else                                                state_reg <= FILL;
          end
        end
        WB: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b1;
            mem_tag  <= tag_reg[line_reg];
            mem_line <= line_reg;
          end else if (mem_ack) begin
            mem_req             <= 1'b0;
            dirty_reg[line_reg] <= 1'b0;
            state_reg           <= FILL;
          end
        end
        FILL: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_tag  <= tag_lat_reg;
            mem_line <= line_reg;
          end else if (mem_ack) begin
            mem_req             <= 1'b0;
            valid_reg[line_reg] <= 1'b1;
            tag_reg[line_reg]   <= tag_lat_reg;
            dirty_reg[line_reg] <= write_reg;
            resp_valid          <= 1'b1;
            resp_hit            <= 1'b0;
            resp_line           <= line_reg;
            state_reg           <= RESP;
          end
        end
        RESP: begin
          age_reg   <= age_next;
          req_ready <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_line_ctrl.sv
// Self-checking bench for cache_line_ctrl: directed scenarios plus random
// accesses, checked against a recency-list model of the set.
module tb_cache_line_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [7:0] req_tag = 8'h00;
  logic       resp_valid;
  logic       resp_hit;
  logic [1:0] resp_line;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_tag;
  logic [1:0] mem_line;
  logic       mem_ack = 1'b0;

  int checks = 0;
  int errors = 0;
  bit stray_ack = 1'b0;

  // Model: line contents plus a recency list (front = most recent).
  bit       m_valid[4];
  bit       m_dirty[4];
  bit [7:0] m_tag[4];
  int       rec[$];

  cache_line_ctrl #(.TAG_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_line(resp_line),
    .mem_req(mem_req), .mem_we(mem_we), .mem_tag(mem_tag), .mem_line(mem_line),
    .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  function automatic int age_of(int l);
    for (int k = 0; k < rec.size(); k++) if (rec[k] == l) return k;
    return -1;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = 8'h00;
    end
    rec = {0, 1, 2, 3};
  endfunction

  task automatic do_reset();
    rst = 1'b1; req_valid = 1'b0; mem_ack = 1'b0; stray_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // One CPU access: drive, serve memory, check every observable against the model.
  task automatic access(input bit wr, input bit [7:0] t, input int ack_dly, input string nm,
                        output bit hit_o);
    int  hl, vic, ntx, exp_ntx, cyc, rcnt, last_high, idx;
    bit  done;
    bit  e_we[2];
    bit [7:0] e_tag[2];
    bit [1:0] e_line[2];
    hl = -1;
    for (int i = 0; i < 4; i++) if (m_valid[i] && m_tag[i] == t) hl = i;
    vic = -1;
    for (int i = 3; i >= 0; i--) if ((!m_valid[i] && !m_dirty[i]) || age_of(i) == 3) vic = i;
    exp_ntx = 0;
    if (hl < 0) begin
      if (m_valid[vic] && m_dirty[vic]) begin
        e_we[0] = 1; e_tag[0] = m_tag[vic]; e_line[0] = 2'(vic);
        e_we[1] = 0; e_tag[1] = t; e_line[1] = 2'(vic); exp_ntx = 2;
      end else begin
        e_we[0] = 0; e_tag[0] = t; e_line[0] = 2'(vic); exp_ntx = 1;
      end
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s ready: got %b want 1", nm, req_ready);
    end
    req_valid = 1'b1; req_write = wr; req_tag = t;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1; rcnt = 0; ntx = 0; done = 0; last_high = -10;
    while (!done && cyc < 200) begin
      if (resp_valid) done = 1;
      else begin
        if (mem_req) begin
          if (rcnt == 0) begin
            ntx++;
            if (ntx == 2) begin
              checks++;
              if (cyc !== last_high + 2) begin
                errors++; $display("FAIL %s wb_fill_gap: fill start %0d want %0d", nm, cyc, last_high + 2);
              end
            end
          end
          idx = (ntx > 2) ? 1 : ntx - 1;
          checks++;
          if (ntx > exp_ntx || mem_we !== e_we[idx] || mem_tag !== e_tag[idx] || mem_line !== e_line[idx]) begin
            errors++;
            $display("FAIL %s mem_tx%0d: got we=%b tag=%h line=%0d want we=%b tag=%h line=%0d (expected %0d tx)",
                     nm, ntx, mem_we, mem_tag, mem_line, e_we[idx], e_tag[idx], e_line[idx], exp_ntx);
          end
          mem_ack = (rcnt >= ack_dly) ? 1'b1 : stray_ack;
          rcnt++;
          last_high = cyc;
        end else begin
          mem_ack = stray_ack; rcnt = 0;
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL %s timeout: no resp_valid after %0d cycles", nm, cyc);
    end
    checks++;
    if (resp_hit !== (hl >= 0) || resp_line !== 2'((hl >= 0) ? hl : vic) || ntx !== exp_ntx) begin
      errors++;
      $display("FAIL %s resp: got hit=%b line=%0d tx=%0d want hit=%b line=%0d tx=%0d",
               nm, resp_hit, resp_line, ntx, hl >= 0, (hl >= 0) ? hl : vic, exp_ntx);
    end
    if (hl >= 0) begin
      checks++;
      if (cyc !== 2) begin
        errors++; $display("FAIL %s hit_latency: got %0d cycles want 2", nm, cyc);
      end
    end
    hit_o = resp_hit;
    mem_ack = stray_ack;
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL %s after_resp: valid=%b ready=%b mem_req=%b want 0 1 0",
                         nm, resp_valid, req_ready, mem_req);
    end
    // Update the model from the access rules.
    if (hl >= 0) begin
      if (wr) m_dirty[hl] = 1;
      idx = hl;
    end else begin
      m_valid[vic] = 1; m_tag[vic] = t; m_dirty[vic] = wr;
      idx = vic;
    end
    rec.delete(age_of(idx));
    rec.push_front(idx);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dut.valid_reg[i] !== m_valid[i] || dut.dirty_reg[i] !== m_dirty[i] ||
          (m_valid[i] && dut.tag_reg[i] !== m_tag[i]) || int'(dut.age_reg[i]) !== age_of(i)) begin
        errors++;
        $display("FAIL %s line%0d: got v=%b d=%b tag=%h age=%0d want v=%b d=%b tag=%h age=%0d", nm, i,
                 dut.valid_reg[i], dut.dirty_reg[i], dut.tag_reg[i], dut.age_reg[i],
                 m_valid[i], m_dirty[i], m_tag[i], age_of(i));
      end
    end
    $display("txn %s wr=%0b tag=%h -> hit=%0b line=%0d mem_tx=%0d", nm, wr, t, hit_o, resp_line, ntx);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 0 || resp_hit !== 0 || resp_line !== 0 ||
        mem_req !== 0 || mem_we !== 0 || mem_tag !== 0 || mem_line !== 0) begin
      errors++; $display("FAIL reset_outputs: ready=%b rv=%b rh=%b rl=%0d mr=%b mw=%b mt=%h ml=%0d",
                         req_ready, resp_valid, resp_hit, resp_line, mem_req, mem_we, mem_tag, mem_line);
    end
    checks++;
    if (dut.valid_reg !== 4'b0 || dut.dirty_reg !== 4'b0 || dut.age_reg !== {2'd3, 2'd2, 2'd1, 2'd0}) begin
      errors++; $display("FAIL reset_state: valid=%b dirty=%b ages=%h want 0 0 e4", dut.valid_reg, dut.dirty_reg, dut.age_reg);
    end
  endtask

  task automatic test_cold_miss();
    bit h;
    access(0, 8'h12, 3, "cold_miss", h);
    checks++;
    if (h !== 1'b0 || dut.valid_reg[0] !== 1'b1) begin
      errors++; $display("FAIL cold_miss_line0: hit=%b valid0=%b want 0 1", h, dut.valid_reg[0]);
    end
  endtask

  task automatic test_read_hit();
    bit h;
    access(0, 8'h12, 3, "read_hit", h);
    checks++;
    if (h !== 1'b1) begin
      errors++; $display("FAIL read_hit_flag: got %b want 1", h);
    end
  endtask

  task automatic test_fill_all();
    bit h;
    do_reset();
    for (int i = 0; i < 4; i++) access(1, 8'h10 + 8'(i), i, "fill_all", h);
    checks++;
    if (dut.dirty_reg !== 4'hf || dut.age_reg !== {2'd0, 2'd1, 2'd2, 2'd3}) begin
      errors++; $display("FAIL fill_all_final: dirty=%b ages=%h want 1111 1b", dut.dirty_reg, dut.age_reg);
    end
  endtask

  task automatic test_dirty_evict();
    bit h;
    access(1, 8'h20, 2, "dirty_evict", h);
    checks++;
    if (resp_line !== 2'd0 || dut.dirty_reg[0] !== 1'b1 || dut.age_reg !== {2'd1, 2'd2, 2'd3, 2'd0}) begin
      errors++; $display("FAIL dirty_evict_final: line=%0d dirty0=%b ages=%h want 0 1 6c",
                         resp_line, dut.dirty_reg[0], dut.age_reg);
    end
  endtask

  task automatic test_reset_during_wb();
    bit h;
    int n;
    test_fill_all();
    req_valid = 1'b1; req_write = 1'b1; req_tag = 8'h30;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1) begin
      errors++; $display("FAIL rst_wb_setup: mem_req=%b mem_we=%b want 1 1", mem_req, mem_we);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    checks++;
    if (mem_req !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0 || dut.valid_reg !== 4'b0) begin
      errors++; $display("FAIL rst_wb_abort: mem_req=%b ready=%b rv=%b valid=%b want 0 1 0 0",
                         mem_req, req_ready, resp_valid, dut.valid_reg);
    end
    access(0, 8'h10, 1, "rst_wb_read", h);
    checks++;
    if (h !== 1'b0) begin
      errors++; $display("FAIL rst_wb_miss: hit=%b want 0", h);
    end
  endtask

  task automatic test_stray_ack();
    bit h;
    do_reset();
    access(0, 8'h55, 0, "stray_setup", h);
    stray_ack = 1'b1;
    mem_ack = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      checks++;
      if (mem_req !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0 || dut.valid_reg !== 4'b0001) begin
        errors++; $display("FAIL stray_idle: mem_req=%b ready=%b rv=%b valid=%b want 0 1 0 0001",
                           mem_req, req_ready, resp_valid, dut.valid_reg);
      end
    end
    access(1, 8'h55, 0, "stray_hit", h);
    checks++;
    if (h !== 1'b1) begin
      errors++; $display("FAIL stray_hit_flag: got %b want 1", h);
    end
    stray_ack = 1'b0;
    mem_ack = 1'b0;
  endtask

  task automatic test_random();
    bit h;
    do_reset();
    for (int n = 0; n < 60; n++)
      access(1'($urandom_range(0, 1)), 8'h40 + 8'($urandom_range(0, 5)), $urandom_range(0, 3), "random", h);
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_read_hit();
    test_fill_all();
    test_dirty_evict();
    test_reset_during_wb();
    test_stray_ack();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
